// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: operand forwarding, load-use stalls and multi-cycle M-extension stalls.
// Define HAZARD_MD_EN to build in the multiply/divide stall path (MD_BUSY/MD_DONE states).
module pipeline_hazard_ctrl #(
    parameter int AW       = 5,
    parameter int LOAD_BUB = 1,
    parameter int MD_LAT   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reg_wrM,
    input  logic          reg_wrW,
    input  logic [1:0]    wb_selE,
    input  logic [AW-1:0] raddr1D,
    input  logic [AW-1:0] raddr2D,
    input  logic [AW-1:0] raddr1E,
    input  logic [AW-1:0] raddr2E,
    input  logic [AW-1:0] waddrE,
    input  logic [AW-1:0] waddrM,
    input  logic [AW-1:0] waddrW,
    input  logic          br_taken,
    input  logic          md_startE,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          flushD,
    output logic          flushE,
    output logic          flushM,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic          md_busy
);

    localparam int MAXC = (LOAD_BUB > MD_LAT) ? LOAD_BUB : MD_LAT;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_STALL = 2'd1
`ifdef HAZARD_MD_EN
        ,
        MD_BUSY  = 2'd2,
        MD_DONE  = 2'd3
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_use;

`ifndef HAZARD_MD_EN
    logic unused_md;
    assign unused_md = md_startE;
`endif

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] ra,
        input logic          wr_m,
        input logic [AW-1:0] wa_m,
        input logic          wr_w,
        input logic [AW-1:0] wa_w
    );
        logic [1:0] sel;
        sel = 2'b01;
        if (ra != '0) begin
            if (wr_m && (wa_m == ra))
                sel = 2'b00;
            else if (wr_w && (wa_w == ra))
                sel = 2'b10;
        end
        return sel;
    endfunction

    assign forwardAE = fwd_sel(raddr1E, reg_wrM, waddrM, reg_wrW, waddrW);
    assign forwardBE = fwd_sel(raddr2E, reg_wrM, waddrM, reg_wrW, waddrW);

    assign load_use = (wb_selE == 2'b10) && (waddrE != '0) &&
                      ((raddr1D == waddrE) || (raddr2D == waddrE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The entry cycle is the first stall cycle, so the counter holds the stall cycles still owed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        md_busy = 1'b0;
        case (state_q)
            IDLE
`ifdef HAZARD_MD_EN
            , MD_DONE
`endif
            : begin
                state_d = IDLE;
                cnt_d   = '0;
                if (br_taken) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end
`ifdef HAZARD_MD_EN
                else if (md_startE && (state_q == IDLE)) begin
                    stallF  = 1'b1;
                    stallD  = 1'b1;
                    stallE  = 1'b1;
                    flushM  = 1'b1;
                    md_busy = 1'b1;
                    state_d = MD_BUSY;
                    cnt_d   = CW'(MD_LAT - 1);
                end
`endif
                else if (load_use) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                    if (LOAD_BUB > 1) begin
                        state_d = LD_STALL;
                        cnt_d   = CW'(LOAD_BUB - 1);
                    end
                end
            end
            LD_STALL: begin
                if (br_taken) begin
                    flushD  = 1'b1;
                    flushE  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
`ifdef HAZARD_MD_EN
            MD_BUSY: begin
                stallF  = 1'b1;
                stallD  = 1'b1;
                stallE  = 1'b1;
                flushM  = 1'b1;
                md_busy = 1'b1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = MD_DONE;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!rst) begin
            stallF  = 1'b0;
            stallD  = 1'b0;
            stallE  = 1'b0;
            flushD  = 1'b0;
            flushE  = 1'b0;
            flushM  = 1'b0;
            md_busy = 1'b0;
        end
    end

endmodule
